// File: rtl/fpdiv_sp.sv
// fpdiv_sp: sequential IEEE-754 single divider, radix-2 restoring, one quotient bit per clock.
// Define FPDIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fpdiv_sp (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        St,
  input  logic [31:0] FPdividend,
  input  logic [31:0] FPdivisor,
  output logic        Done,
  output logic        Ovf,
  output logic        Unf,
  output logic        Dz,
  output logic [31:0] FPquotient
);
  typedef enum logic [2:0] {IDLE, LOAD, DIV, NORM, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_a, r_b;
  logic [4:0] r_cnt;
  logic signed [9:0] r_exp;
  logic [23:0] r_m2;
  logic [25:0] r_r, r_q;
  logic w_s, w_e1z, w_e2z, w_ge, w_hi, w_inc, w_ovf, w_unf;
  logic [24:0] w_diff;
  logic [22:0] w_frac;
  logic [23:0] w_fr;
  logic signed [9:0] w_e, w_er;
  assign w_s    = r_a[31] ^ r_b[31];
  assign w_e1z  = r_a[30:23] == 8'd0;
  assign w_e2z  = r_b[30:23] == 8'd0;
  assign w_ge   = r_r >= {2'b0, r_m2};
  assign w_diff = r_r[24:0] - {1'b0, r_m2};
  assign w_hi   = r_q[25];
  assign w_frac = w_hi ? r_q[24:2] : r_q[23:1];
  assign w_e    = w_hi ? r_exp : r_exp - 10'sd1;
`ifdef FPDIV_RNE_EN
  logic w_g, w_st;
  assign w_g   = w_hi ? r_q[1] : r_q[0];
  assign w_st  = (w_hi & r_q[0]) | (r_r != 26'd0);
  assign w_inc = w_g & (w_st | w_frac[0]);
`else
  assign w_inc = 1'b0;
`endif
  // a rounding carry out of frac leaves frac=0 and bumps the exponent
  assign w_fr  = {1'b0, w_frac} + {23'd0, w_inc};
  assign w_er  = w_e + $signed({9'd0, w_fr[23]});
  assign w_ovf = w_er >= 10'sd255;
  assign w_unf = w_er <= 10'sd0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = St ? LOAD : IDLE;
      LOAD:    w_next = (w_e1z | w_e2z) ? DONE : DIV;
      DIV:     w_next = (r_cnt == 5'd25) ? NORM : DIV;
      NORM:    w_next = DONE;
      DONE:    w_next = St ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_exp <= '0;
      r_m2 <= '0;
      r_r <= '0;
      r_q <= '0;
      Done <= 1'b0;
      Ovf <= 1'b0;
      Unf <= 1'b0;
      Dz <= 1'b0;
      FPquotient <= '0;
    end else begin
      case (r_state)
        IDLE: if (St) begin
          r_a <= FPdividend;
          r_b <= FPdivisor;
          FPquotient <= '0;
          Ovf <= 1'b0;
          Unf <= 1'b0;
          Dz <= 1'b0;
        end
        LOAD: begin
          r_exp <= $signed({2'b0, r_a[30:23]}) - $signed({2'b0, r_b[30:23]}) + 10'sd127;
          r_m2 <= {1'b1, r_b[22:0]};
          r_r <= {2'b0, 1'b1, r_a[22:0]};
          r_q <= '0;
          r_cnt <= '0;
          if (w_e2z) begin
            Dz <= 1'b1;
            FPquotient <= w_e1z ? 32'h7FC00000 : {w_s, 8'hFF, 23'h0};
            Done <= 1'b1;
          end else if (w_e1z) begin
            FPquotient <= {w_s, 31'h0};
            Done <= 1'b1;
          end
        end
        DIV: begin
          r_q <= {r_q[24:0], w_ge};
          r_r <= {(w_ge ? w_diff : r_r[24:0]), 1'b0};
          r_cnt <= (r_cnt == 5'd25) ? 5'd0 : r_cnt + 5'd1;
        end
        NORM: begin
          Ovf <= w_ovf;
          Unf <= ~w_ovf & w_unf;
          FPquotient <= w_ovf ? {w_s, 8'hFF, 23'h0} : w_unf ? {w_s, 31'h0} : {w_s, w_er[7:0], w_fr[22:0]};
          Done <= 1'b1;
        end
        DONE: if (!St) Done <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fpdiv_sp.sv
// tb_fpdiv_sp: table-driven checks of fpdiv_sp plus handshake and async-reset sequences.
module tb_fpdiv_sp;
  logic Clk = 1'b0, Rst = 1'b1, St = 1'b0;
  logic [31:0] FPdividend = '0, FPdivisor = '0;
  logic Done, Ovf, Unf, Dz;
  logic [31:0] FPquotient;
  int n_tests = 0, n_fail = 0;
  fpdiv_sp dut (.Clk(Clk), .Rst(Rst), .St(St), .FPdividend(FPdividend), .FPdivisor(FPdivisor),
                .Done(Done), .Ovf(Ovf), .Unf(Unf), .Dz(Dz), .FPquotient(FPquotient));
  always #5 Clk = ~Clk;
  typedef struct {
    logic [31:0] a, b, q;
    logic [2:0] flags;
    int lat;
  } vec_t;
  vec_t vecs[10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic hold, output int lat);
    @(negedge Clk);
    FPdividend = a;
    FPdivisor = b;
    St = 1'b1;
    @(posedge Clk);
    #1;
    if (!hold) St = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      @(posedge Clk);
      #1;
      lat++;
    end
  endtask
  initial begin
    int lat;
    vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28};
`ifdef FPDIV_RNE_EN
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 28};
    vecs[2] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 3'b000, 28};
`else
    vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 28};
    vecs[2] = '{32'h40000000, 32'h40400000, 32'h3F2AAAAA, 3'b000, 28};
`endif
    vecs[3] = '{32'hBF800000, 32'h3F000000, 32'hC0000000, 3'b000, 28};
    vecs[4] = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 3'b100, 28};
    vecs[5] = '{32'h00800000, 32'h40000000, 32'h00000000, 3'b010, 28};
    vecs[6] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 1};
    vecs[7] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 3'b001, 1};
    vecs[8] = '{32'h80000000, 32'h40A00000, 32'h80000000, 3'b000, 1};
    vecs[9] = '{32'h40400000, 32'h3FC00000, 32'h40000000, 3'b000, 28};
    #2;
    chk("reset_out", {Done, Ovf, Unf, Dz, FPquotient}, 36'h0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_quotient", i), FPquotient, vecs[i].q);
      chk($sformatf("v%0d_flags", i), {29'd0, Ovf, Unf, Dz}, {29'd0, vecs[i].flags});
      @(posedge Clk);
      #1;
      chk($sformatf("v%0d_done_fall", i), {31'd0, Done}, 32'd0);
      chk($sformatf("v%0d_hold", i), FPquotient, vecs[i].q);
    end
    // St held high: Done stays up and the block parks in DONE until St drops
    start_op(32'h40C00000, 32'h40000000, 1'b1, lat);
    chk("hold_latency", 32'(lat), 32'd28);
    repeat (3) @(posedge Clk);
    #1;
    chk("hold_done", {31'd0, Done}, 32'd1);
    chk("hold_q", FPquotient, 32'h40400000);
    @(negedge Clk);
    St = 1'b0;
    @(posedge Clk);
    #1;
    chk("hold_release", {31'd0, Done}, 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("no_retrigger", {31'd0, Done}, 32'd0);
    // async reset pulse between edges, during DIV iteration 10
    @(negedge Clk);
    FPdividend = 32'h7F000000;
    FPdivisor = 32'h3E800000;
    St = 1'b1;
    @(posedge Clk);
    #1;
    St = 1'b0;
    repeat (10) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    chk("async_rst_out", {Done, Ovf, Unf, Dz, FPquotient}, 36'h0);
    chk("async_rst_state", 32'(dut.r_state), 32'd0);
    #1;
    Rst = 1'b0;
    lat = 0;
    while (!Done && lat < 40) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    chk("aborted_no_done", {31'd0, Done}, 32'd0);
    start_op(32'h40C00000, 32'h40000000, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd28);
    chk("post_rst_q", FPquotient, 32'h40400000);
    chk("post_rst_flags", {29'd0, Ovf, Unf, Dz}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
